// File: rtl/macc_compute_pkg.sv
// Shared constants, FSM state encoding and small helpers for the MACC compute sequencer.
package macc_compute_pkg;

   localparam int MACC_DATA_W  = 32;  // element, product and accumulator width
   localparam int RAM_ADDR_MSB = 11;  // 4096-word BRAMs
   localparam int MACC_IDX_W   = 6;   // row/column index width; address = {row, col}
   localparam int DIM_LOG2_MAX = 6;   // largest supported matrix is 64x64
   localparam int DRAIN_CYCLES = 2;   // pipeline depth between the last read and a valid acc

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // True when the requested matrix size fits the index counters.
   function automatic logic dim_legal(input logic [3:0] dim_log2);
      return dim_log2 <= 4'(DIM_LOG2_MAX);
   endfunction

endpackage : macc_compute_pkg

// File: rtl/macc_mul_acc.sv
// Multiply-accumulate datapath: BRAM data arrives one cycle after the read strobe,
// the product is registered, then folded into the accumulator (restarted on 'first').
module macc_mul_acc
   import macc_compute_pkg::*;
#(
   parameter int DATA_W = MACC_DATA_W
) (
   input  logic              CLK,
   input  logic              RST_L,
   input  logic              in_valid,  // read strobe issued this cycle
   input  logic              in_first,  // this read starts a new dot product
   input  logic [DATA_W-1:0] a,         // A BRAM dout, valid the cycle after in_valid
   input  logic [DATA_W-1:0] b,         // B BRAM dout, valid the cycle after in_valid
   output logic [DATA_W-1:0] acc
);

   logic              v1_q, f1_q;  // tags aligned with BRAM read data
   logic              v2_q, f2_q;  // tags aligned with prod_q
   logic [DATA_W-1:0] prod_q;
   logic [DATA_W-1:0] acc_q;

   // Delay the valid/first tags by one cycle to line up with the BRAM dout.
   // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         v1_q <= 1'b0;
         f1_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
         f1_q <= in_first;
      end
   end

   // Register the low DATA_W bits of the product; arithmetic wraps mod 2^DATA_W.
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         v2_q   <= 1'b0;
         f2_q   <= 1'b0;
         prod_q <= '0;
      end else begin
         v2_q <= v1_q;
         f2_q <= f1_q;
         if (v1_q) begin
            prod_q <= a * b;
         end
      end
   end

   // Accumulate, restarting from the product on the first term of each dot product.
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         acc_q <= '0;
      end else if (v2_q) begin
         acc_q <= f2_q ? prod_q : acc_q + prod_q;
      end
   end

   assign acc = acc_q;

endmodule : macc_mul_acc

// File: rtl/macc_compute.sv
// Compute sequencer for the matrix accelerator: walks i/j/k over an n x n product,
// streams A{i,k} and B{k,j} through the MAC pipeline and writes each C{i,j}.
module macc_compute
   import macc_compute_pkg::*;
#(
   parameter int DATA_W   = MACC_DATA_W,
   parameter int ADDR_MSB = RAM_ADDR_MSB,
   parameter int IDX_W    = MACC_IDX_W
) (
   input  logic                CLK,
   input  logic                RST_L,
   input  logic                start,
   input  logic                abort,
   input  logic [3:0]          dim_log2,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                rd_en,
   output logic [ADDR_MSB:0]   a_addr,
   output logic [ADDR_MSB:0]   b_addr,
   input  logic [DATA_W-1:0]   a_rdata,
   input  logic [DATA_W-1:0]   b_rdata,
   output logic                c_we,
   output logic [ADDR_MSB:0]   c_addr,
   output logic [DATA_W-1:0]   c_wdata
);

   localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   i_q, i_d;        // C row
   logic [IDX_W-1:0]   j_q, j_d;        // C column
   logic [IDX_W-1:0]   k_q, k_d;        // dot-product term
   logic [IDX_W-1:0]   last_q, last_d;  // n-1 for the current run
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               err_q, err_d;
   logic [IDX_W-1:0]   last_req;        // n-1 derived from the requested dim_log2

   // n-1 is a mask of dim_log2 low ones; only meaningful for legal sizes.
   assign last_req = ~({IDX_W{1'b1}} << dim_log2);

   // Next-state and counter updates; abort overrides everything and freezes the counters
   // so the BRAM addresses keep their last value while idle.
   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      last_d  = last_q;
      drain_d = drain_q;
      err_d   = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (dim_legal(dim_log2)) begin
                     last_d  = last_req;
                     i_d     = '0;
                     j_d     = '0;
                     k_d     = '0;
                     state_d = ST_ISSUE;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (k_q == last_q) begin
                  drain_d = '0;
                  state_d = ST_DRAIN;
               end else begin
                  k_d = k_q + IDX_W'(1);
               end
            end
            ST_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  state_d = ST_WRITE;
               end else begin
                  drain_d = drain_q + DRAIN_W'(1);
               end
            end
            ST_WRITE: begin
               if (j_q != last_q) begin
                  j_d     = j_q + IDX_W'(1);
                  k_d     = '0;
                  state_d = ST_ISSUE;
               end else if (i_q != last_q) begin
                  j_d     = '0;
                  i_d     = i_q + IDX_W'(1);
                  k_d     = '0;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counter and error-pulse registers.
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         last_q  <= '0;
         drain_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         last_q  <= last_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end

   // Strobes decode the registered state; addresses are the registered counters.
   assign busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);
   assign done   = (state_q == ST_DONE);
   assign rd_en  = (state_q == ST_ISSUE);
   assign c_we   = (state_q == ST_WRITE);
   assign err    = err_q;
   assign a_addr = {i_q, k_q};
   assign b_addr = {k_q, j_q};
   assign c_addr = {i_q, j_q};

   macc_mul_acc #(
      .DATA_W (DATA_W)
   ) u_mul_acc (
      .CLK      (CLK),
      .RST_L    (RST_L),
      .in_valid (rd_en),
      .in_first (rd_en && (k_q == '0)),
      .a        (a_rdata),
      .b        (b_rdata),
      .acc      (c_wdata)
   );

endmodule : macc_compute

// File: tb/tb_macc_compute.sv
// Directed testbench for macc_compute with behavioural A/B/C BRAMs around the DUT.
module tb_macc_compute;

   logic        CLK      = 1'b0;
   logic        RST_L    = 1'b0;
   logic        start    = 1'b0;
   logic        abort    = 1'b0;
   logic [3:0]  dim_log2 = 4'd0;
   logic        busy, done, err, rd_en, c_we;
   logic [11:0] a_addr, b_addr, c_addr;
   logic [31:0] a_rdata = '0;
   logic [31:0] b_rdata = '0;
   logic [31:0] c_wdata;

   logic [31:0] a_mem [4096];
   logic [31:0] b_mem [4096];
   logic [31:0] c_mem [4096];
   logic [31:0] exp_c [4096];

   int tests_run = 0;
   int failed    = 0;

   // Monitor state
   logic clear_c  = 1'b0;
   int   cur_last = 0;
   int   we_cnt, rd_cnt, done_cnt, bad_addr;

   always #5 CLK = ~CLK;

   macc_compute dut (
      .CLK      (CLK),
      .RST_L    (RST_L),
      .start    (start),
      .abort    (abort),
      .dim_log2 (dim_log2),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rd_en    (rd_en),
      .a_addr   (a_addr),
      .b_addr   (b_addr),
      .a_rdata  (a_rdata),
      .b_rdata  (b_rdata),
      .c_we     (c_we),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata)
   );

   // BRAMs: 1-cycle read latency on A/B, synchronous write on C
   always @(posedge CLK) begin
      if (rd_en) begin
         a_rdata <= a_mem[a_addr];
         b_rdata <= b_mem[b_addr];
      end
      if (clear_c) begin
         for (int i = 0; i < 4096; i++) c_mem[i] <= 32'hDEAD_BEEF;
      end else if (c_we) begin
         c_mem[c_addr] <= c_wdata;
      end
   end

   // Event counters and address-range monitor, sampled on the falling edge
   always @(negedge CLK) begin
      if (clear_c) begin
         we_cnt   <= 0;
         rd_cnt   <= 0;
         done_cnt <= 0;
         bad_addr <= 0;
      end else begin
         if (c_we) we_cnt <= we_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
         if (rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (int'(a_addr[11:6]) > cur_last || int'(a_addr[5:0]) > cur_last ||
                int'(b_addr[11:6]) > cur_last || int'(b_addr[5:0]) > cur_last)
               bad_addr <= bad_addr + 1;
         end
         if (c_we && (int'(c_addr[11:6]) > cur_last || int'(c_addr[5:0]) > cur_last))
            bad_addr <= bad_addr + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clear_monitors();
      clear_c = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      #1 clear_c = 1'b0;
   endtask

   // Run one full multiply of size 2^dim and check timing, counts and the C contents.
   // poke_at > 0 pulses start (with a different size) at that cycle after S.
   task automatic run_mm(input logic [3:0] dim, input int poke_at, input string name);
      int n, exp_done, t, busy_gaps, mism;
      n        = 1 << dim;
      exp_done = 1 + n * n * (n + 3);
      cur_last = n - 1;
      clear_monitors();
      @(negedge CLK);
      dim_log2  = dim;
      start     = 1'b1;
      @(negedge CLK);
      start     = 1'b0;
      t         = 1;
      busy_gaps = 0;
      while (done !== 1'b1 && t < exp_done + 50) begin
         if (busy !== 1'b1) busy_gaps++;
         if (t == poke_at) begin
            start    = 1'b1;
            dim_log2 = 4'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge CLK);
         t++;
      end
      start = 1'b0;
      tests_run++;
      if (t !== exp_done || done !== 1'b1) begin
         failed++;
         $display("FAIL %s done_cycle: got S+%0d (done=%b), expected S+%0d", name, t, done, exp_done);
      end
      tests_run++;
      if (busy_gaps !== 0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL %s busy_window: %0d gaps, busy=%b in done cycle, expected 0 gaps and 0", name, busy_gaps, busy);
      end
      @(negedge CLK);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL %s after_done: done=%b busy=%b, expected 0 0", name, done, busy);
      end
      repeat (2) @(negedge CLK);
      #1;
      tests_run++;
      if (we_cnt !== n * n || rd_cnt !== n * n * n || done_cnt !== 1 || bad_addr !== 0) begin
         failed++;
         $display("FAIL %s counts: c_we=%0d rd_en=%0d done=%0d bad_addr=%0d, expected %0d %0d 1 0",
                  name, we_cnt, rd_cnt, done_cnt, bad_addr, n * n, n * n * n);
      end
      mism = 0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            if (c_mem[i * 64 + j] !== exp_c[i * 64 + j]) begin
               if (mism < 4)
                  $display("FAIL %s C[%0d][%0d]: got %h, expected %h", name, i, j,
                           c_mem[i * 64 + j], exp_c[i * 64 + j]);
               mism++;
            end
         end
      end
      tests_run++;
      if (mism !== 0) begin
         failed++;
         $display("FAIL %s c_contents: %0d wrong elements, expected 0", name, mism);
      end
   endtask

   task automatic test_reset();
      RST_L = 1'b0;
      repeat (2) @(negedge CLK);
      tests_run++;
      if ({busy, done, err, rd_en, a_addr, b_addr, c_we, c_addr, c_wdata} !== '0) begin
         failed++;
         $display("FAIL reset_outputs: busy=%b done=%b err=%b rd_en=%b a=%h b=%h we=%b c=%h wd=%h, expected all 0",
                  busy, done, err, rd_en, a_addr, b_addr, c_we, c_addr, c_wdata);
      end
      RST_L = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_n2();
      a_mem[0] = 1; a_mem[1] = 2; a_mem[64] = 3; a_mem[65] = 4;
      b_mem[0] = 5; b_mem[1] = 6; b_mem[64] = 7; b_mem[65] = 8;
      exp_c[0] = 19; exp_c[1] = 22; exp_c[64] = 43; exp_c[65] = 50;
      run_mm(4'd1, 0, "n2");
   endtask

   task automatic test_n1();
      a_mem[0] = 32'd7;
      b_mem[0] = 32'hFFFF_FFFD;
      exp_c[0] = 32'hFFFF_FFEB;
      run_mm(4'd0, 0, "n1");
   endtask

   task automatic test_wrap();
      foreach (exp_c[idx]) exp_c[idx] = 32'hFFFF_FFFC;
      a_mem[0] = 32'h7FFF_FFFF; a_mem[1] = 32'h7FFF_FFFF; a_mem[64] = 32'h7FFF_FFFF; a_mem[65] = 32'h7FFF_FFFF;
      b_mem[0] = 2; b_mem[1] = 2; b_mem[64] = 2; b_mem[65] = 2;
      run_mm(4'd1, 0, "wrap");
   endtask

   task automatic test_err();
      int seen_bad;
      clear_monitors();
      @(negedge CLK);
      dim_log2 = 4'd7;
      start    = 1'b1;
      @(negedge CLK);
      start    = 1'b0;
      tests_run++;
      if (err !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
         failed++;
         $display("FAIL err_pulse: err=%b busy=%b rd_en=%b, expected 1 0 0", err, busy, rd_en);
      end
      @(negedge CLK);
      tests_run++;
      if (err !== 1'b0) begin
         failed++;
         $display("FAIL err_width: err=%b one cycle later, expected 0", err);
      end
      seen_bad = 0;
      repeat (4) begin
         if (busy !== 1'b0 || rd_en !== 1'b0 || c_we !== 1'b0 || err !== 1'b0) seen_bad++;
         @(negedge CLK);
      end
      tests_run++;
      if (seen_bad !== 0) begin
         failed++;
         $display("FAIL err_idle: %0d cycles with activity after bad start, expected 0", seen_bad);
      end
      // abort and start together: abort wins
      dim_log2 = 4'd1;
      start    = 1'b1;
      abort    = 1'b1;
      @(negedge CLK);
      start    = 1'b0;
      abort    = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         failed++;
         $display("FAIL abort_start: busy=%b rd_en=%b, expected 0 0", busy, rd_en);
      end
   endtask

   task automatic load_n4();
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            a_mem[i * 64 + k] = 32'(i * 4 + k + 1);
            b_mem[i * 64 + k] = 32'((i + 1) * (k + 2)) + 32'h1000_0000;
         end
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            logic [31:0] s;
            s = '0;
            for (int k = 0; k < 4; k++) s = s + a_mem[i * 64 + k] * b_mem[k * 64 + j];
            exp_c[i * 64 + j] = s;
         end
      end
   endtask

   task automatic test_reset_mid_issue();
      load_n4();
      @(negedge CLK);
      dim_log2 = 4'd2;
      start    = 1'b1;
      @(negedge CLK);
      start    = 1'b0;
      @(negedge CLK);
      RST_L = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, err, rd_en, a_addr, b_addr, c_we, c_addr, c_wdata} !== '0) begin
         failed++;
         $display("FAIL reset_mid_issue: busy=%b rd_en=%b a=%h b=%h we=%b c=%h wd=%h, expected all 0",
                  busy, rd_en, a_addr, b_addr, c_we, c_addr, c_wdata);
      end
      @(negedge CLK);
      RST_L = 1'b1;
      run_mm(4'd2, 0, "after_reset");
   endtask

   task automatic test_abort_drain();
      int t;
      cur_last = 3;
      clear_monitors();
      @(negedge CLK);
      dim_log2 = 4'd2;
      start    = 1'b1;
      @(negedge CLK);
      start    = 1'b0;
      t = 1;
      while (rd_en === 1'b1 && t < 20) begin
         @(negedge CLK);
         t++;
      end
      tests_run++;
      if (t !== 5 || busy !== 1'b1) begin
         failed++;
         $display("FAIL drain_entry: rd_en dropped at S+%0d busy=%b, expected S+5 and 1", t, busy);
      end
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || c_we !== 1'b0 || done !== 1'b0) begin
         failed++;
         $display("FAIL abort_next: busy=%b c_we=%b done=%b, expected 0 0 0", busy, c_we, done);
      end
      repeat (6) @(negedge CLK);
      #1;
      tests_run++;
      if (we_cnt !== 0 || done_cnt !== 0) begin
         failed++;
         $display("FAIL abort_quiet: c_we=%0d done=%0d after abort, expected 0 0", we_cnt, done_cnt);
      end
      run_mm(4'd2, 0, "after_abort");
   endtask

   task automatic test_start_while_busy();
      run_mm(4'd2, 7, "start_busy");
   endtask

   task automatic test_identity16();
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            a_mem[i * 64 + j] = (i == j) ? 32'd1 : 32'd0;
            b_mem[i * 64 + j] = $urandom;
            exp_c[i * 64 + j] = b_mem[i * 64 + j];
         end
      end
      run_mm(4'd4, 0, "identity16");
   endtask

   initial begin
      foreach (a_mem[idx]) begin
         a_mem[idx] = '0;
         b_mem[idx] = '0;
         exp_c[idx] = '0;
      end
      test_reset();
      test_n2();
      test_n1();
      test_wrap();
      test_err();
      test_reset_mid_issue();
      test_abort_drain();
      test_start_while_busy();
      test_identity16();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule : tb_macc_compute

// File: doc/macc_compute.md
Name: macc_compute

Overview:
- Compute sequencer for the matrix accelerator; computes C = A x B for square matrices of runtime size n = 2^dim_log2, up to 64x64.
- Drives read addresses into the A and B BRAMs and consumes their 1-cycle read data.
- Runs a multiply-accumulate pipeline and writes each finished dot product into the C BRAM.
- Sits directly downstream of the A/B BRAM datapaths and upstream of the C BRAM write port; active while the host-load address controllers are idle.

Parameters:
- DATA_W, 32, width of matrix elements, product and accumulator.
- ADDR_MSB, 11, MSB of the BRAM address (4096 words).
- IDX_W, 6, bits per row/column index; address = {row[IDX_W-1:0], col[IDX_W-1:0]}.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_L  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a multiply; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle, no done.
- dim_log2  in  4  log2(n); latched on an accepted start; legal range 0..6.
- busy  out  1  high from the first ISSUE cycle through the last WRITE cycle.
- done  out  1  one-cycle pulse after the last C element is written.
- err  out  1  one-cycle pulse when start is seen with dim_log2 > 6.
- rd_en  out  1  read strobe to the A and B BRAMs.
- a_addr  out  ADDR_MSB+1  A address {i,k}.
- b_addr  out  ADDR_MSB+1  B address {k,j}.
- a_rdata  in  DATA_W  A BRAM dout; valid the cycle after rd_en.
- b_rdata  in  DATA_W  B BRAM dout; valid the cycle after rd_en.
- c_we  out  1  C BRAM write enable.
- c_addr  out  ADDR_MSB+1  C address {i,j}.
- c_wdata  out  DATA_W  accumulated dot product.

Behaviour:
- Reset (async, RST_L low): state=IDLE; i, j, k, acc and pipeline valids all cleared. Every output is 0: busy, done, err, rd_en, a_addr, b_addr, c_we, c_addr, c_wdata. Reset mid-operation discards all work; no partial write completes.
- IDLE: start with dim_log2<=6 latches n=1<<dim_log2, clears i=j=k=0, goes to ISSUE. start with dim_log2>6 pulses err for 1 cycle and stays in IDLE.
- ISSUE (one cycle per k): rd_en=1, a_addr={i,k}, b_addr={k,j}. Tags the access first=(k==0). When k==n-1, goes to DRAIN; otherwise k++.
- Pipeline:
  - rd_en in cycle T gives data in T+1.
  - prod_q <= a_rdata*b_rdata (low DATA_W bits) at the end of T+1.
  - acc <= first ? prod_q : acc+prod_q at the end of T+2.
  - Signedness is irrelevant: all arithmetic is mod 2^32, wrap with no saturation.
- DRAIN: exactly 2 cycles with rd_en=0, then WRITE.
- WRITE (1 cycle): c_we=1, c_addr={i,j}, c_wdata=acc. Then:
  - if j<n-1: j++, k=0, go to ISSUE;
  - else if i<n-1: j=0, i++, k=0, go to ISSUE;
  - else go to DONE.
- DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Output hold: a_addr and b_addr hold their last value when rd_en=0. c_addr and c_wdata are don't-care when c_we=0 but are driven registered.
- Timing: each C element takes n+3 cycles. With start sampled in cycle S, ISSUE begins at S+1 and done is high in cycle S+1+n^2*(n+3).
- start while not in IDLE is ignored.
- abort in any non-IDLE state: next cycle is IDLE, busy=0, no c_we and no done. If abort coincides with a WRITE, that write still occurs, since c_we is registered from the current state.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- Index counters are IDX_W bits and compared against n-1, so there is no wrap past n. Addresses never exceed {n-1,n-1}.

Decomposition:
- Shared include macc_defs.vh holds RAM_ADDR_MSB=11, IDX_W=6, DIM_LOG2_MAX=6, DRAIN_CYCLES=2, and the FSM state encodings (IDLE, ISSUE, DRAIN, WRITE, DONE).
- One sub-module, macc_mul_acc: the product register plus accumulator with the first-tag valid pipeline. Ports: CLK, RST_L, in_valid, in_first, a, b, acc.
- The top holds the FSM and the i/j/k counters.

Test Plan:
- n=2 (dim_log2=1). A@{0,1,64,65}=1,2,3,4; B=5,6,7,8 -> C@{0,1,64,65}=19,22,43,50. busy high S+1..S+20, done at S+21, exactly 4 c_we pulses.
- n=1 (dim_log2=0). A[0]=7, B[0]=0xFFFFFFFD -> C[0]=0xFFFFFFEB; done at S+5.
- Wrap: n=2, all A=0x7FFFFFFF, all B=2 -> every C element 0xFFFFFFFC.
- dim_log2=7 with start -> err pulses 1 cycle; busy, rd_en and c_we stay 0.
- Abort/reset/start-while-busy, n=4:
  - RST_L low during ISSUE -> all outputs 0 immediately.
  - abort during DRAIN -> IDLE next cycle with no c_we.
  - start pulsed while busy -> ignored.
  - A fresh run after each yields correct C with no stale acc.
- n=64, A=identity, B random -> C==B everywhere; done at S+1+274432. No address beyond 0xFFF and no rd_en outside ISSUE.
